// File: rtl/go_arb.sv
// -----------------------------------------------------------------------------
// go_arb
//
// Round-robin arbiter that funnels single-cycle "go" pulses from NREQ
// requesters onto one shared go channel (typically a pulse CDC). Each request
// is captured in a one-deep pending bit. When idle and enabled, the arbiter
// grants one pending requester. It then emits a one-cycle go_o pulse and
// holds off for GAP guard cycles, so the channel behind it has time to settle.
//
// Parameters
//   NREQ : number of requesters (2..16)
//   GAP  : idle guard cycles after each issued pulse (0..255)
//   IDW  : requester ID width
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   go_i       : per-requester single-cycle go pulses
//   en_i       : issue enable; low blocks new grants only
//   go_o       : one-cycle go pulse per grant (decoded from registered state)
//   id_o       : ID of the requester owning the latest go_o, held until the next grant
//   pend_o     : registered pending-request vector
//   busy_o     : high whenever the FSM is not idle
//   lost_cnt_o : saturating count of dropped requests; present only when
//                GO_ARB_LOST_CNT_EN is defined
//
// Optional feature macro: GO_ARB_LOST_CNT_EN
// -----------------------------------------------------------------------------
module go_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned GAP  = 6,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] go_i,
   input  logic            en_i,
   output logic            go_o,
   output logic [IDW-1:0]  id_o,
   output logic [NREQ-1:0] pend_o,
   output logic            busy_o
`ifdef GO_ARB_LOST_CNT_EN
   ,
   output logic [7:0]      lost_cnt_o
`endif
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StFire = 2'd1,
      StGap  = 2'd2
   } state_e;

   // Guard counter reload value; only meaningful when GAP > 0.
   localparam logic [7:0] GapLoad = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
   localparam logic [IDW-1:0] LastIdx = IDW'(NREQ - 1);

   state_e          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [NREQ-1:0] pend_q, pend_d;
   logic [IDW-1:0]  id_q, id_d;
   // Index with the highest priority on the next search.
   logic [IDW-1:0]  ptr_q, ptr_d;

   logic            grant;
   logic            win_found;
   logic [IDW-1:0]  win_idx;
   logic [IDW-1:0]  win_nxt;
   logic [IDW-1:0]  scan;
   logic [NREQ-1:0] grant_mask;

   // --------------------------------------------------------------------------
   // Round-robin search: walk the pending bits starting at ptr_q, wrapping at
   // NREQ-1, and take the first one set.
   // --------------------------------------------------------------------------
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan      = ptr_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!win_found && pend_q[scan]) begin
            win_found = 1'b1;
            win_idx   = scan;
         end
         scan = (scan == LastIdx) ? '0 : scan + IDW'(1);
      end
   end

   assign win_nxt = (win_idx == LastIdx) ? '0 : win_idx + IDW'(1);

   // A grant can only start from idle; FIRE and GAP are never interrupted.
   assign grant = (state_q == StIdle) && en_i && win_found;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               state_d = StFire;
            end
         end
         StFire: begin
            if (GAP == 0) begin
               state_d = StIdle;
            end else begin
               state_d = StGap;
               cnt_d   = GapLoad;
            end
         end
         StGap: begin
            if (cnt_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs, decoded from registered state only so go_o is glitch-free
   // --------------------------------------------------------------------------
   always_comb begin
      go_o   = (state_q == StFire);
      busy_o = (state_q != StIdle);
   end

   // --------------------------------------------------------------------------
   // Pending bits, winner ID and round-robin pointer
   // --------------------------------------------------------------------------
   always_comb begin
      grant_mask = '0;
      if (grant) begin
         grant_mask[win_idx] = 1'b1;
      end
      // The new request is ORed in after the clear, so a request that lands on
      // its own grant edge survives. A request that is already pending
      // collapses into the existing bit.
      pend_d = (pend_q & ~grant_mask) | go_i;
      id_d   = grant ? win_idx : id_q;
      ptr_d  = grant ? win_nxt : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         id_q   <= '0;
         ptr_q  <= '0;
      end else begin
         pend_q <= pend_d;
         id_q   <= id_d;
         ptr_q  <= ptr_d;
      end
   end

   assign id_o   = id_q;
   assign pend_o = pend_q;

`ifdef GO_ARB_LOST_CNT_EN
   // --------------------------------------------------------------------------
   // Lost-request counter: a request is lost when its bit is already pending
   // and is not being cleared by a grant on the same edge.
   // --------------------------------------------------------------------------
   logic [NREQ-1:0] lost_vec;
   logic [4:0]      lost_num;
   logic [8:0]      lost_sum;
   logic [7:0]      lost_cnt_q, lost_cnt_d;

   always_comb begin
      lost_vec = go_i & pend_q & ~grant_mask;
      lost_num = 5'd0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         lost_num = lost_num + 5'(lost_vec[i]);
      end
      lost_sum   = {1'b0, lost_cnt_q} + 9'(lost_num);
      lost_cnt_d = (lost_sum > 9'd255) ? 8'hff : lost_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lost_cnt_q <= 8'd0;
      end else begin
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_go_arb.sv
// -----------------------------------------------------------------------------
// tb_go_arb
//
// Testbench for go_arb (NREQ=4, GAP=6). It runs directed scenarios first and
// randomized traffic after. A time-based reference model predicts the outputs:
// a grant is decided in any cycle at or after the earliest free cycle, fires on
// the next cycle, and blocks the arbiter for GAP+2 cycles in total. Each
// issued go_o is logged with its cycle number and ID so that pulse spacing and
// ordering can be checked directly.
// -----------------------------------------------------------------------------
module tb_go_arb;

   localparam int NREQ = 4;
   localparam int GAP  = 6;
   localparam int IDW  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] go_i;
   logic            en_i;
   logic            go_o;
   logic [IDW-1:0]  id_o;
   logic [NREQ-1:0] pend_o;
   logic            busy_o;
`ifdef GO_ARB_LOST_CNT_EN
   logic [7:0]      lost_cnt_o;
`endif

   go_arb #(
      .NREQ (NREQ),
      .GAP  (GAP),
      .IDW  (IDW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .go_i   (go_i),
      .en_i   (en_i),
      .go_o   (go_o),
      .id_o   (id_o),
      .pend_o (pend_o),
      .busy_o (busy_o)
`ifdef GO_ARB_LOST_CNT_EN
      ,
      .lost_cnt_o (lost_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n      = 0;   // current cycle number
   bit valid  = 1'b0;

   // Reference model state
   logic [NREQ-1:0] pend_m;
   logic [IDW-1:0]  id_m;
   int              fire_c;    // cycle in which the latest go_o is expected
   int              free_at;   // earliest cycle a new grant may be decided
   int              last_w;    // last winner (NREQ-1 after reset)
   int              lost_m;

   // Observed go_o pulses
   int ev_t[$];
   int ev_id[$];

   int t;
   int u;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend_m  = '0;
      id_m    = '0;
      fire_c  = -1000;
      free_at = n + 1;
      last_w  = NREQ - 1;
      lost_m  = 0;
   endtask

   task automatic model_adv(input logic [NREQ-1:0] g, input logic e);
      logic [NREQ-1:0] clr;
      int              start;
      int              k;
      int              lost_now;
      clr = '0;
      if (n >= free_at && e && pend_m != '0) begin
         start = last_w;
         for (int i = 1; i <= NREQ; i++) begin
            k = (start + i) % NREQ;
            if (clr == '0 && pend_m[k]) begin
               clr[k] = 1'b1;
               id_m   = IDW'(k);
               last_w = k;
            end
         end
         fire_c  = n + 1;
         free_at = n + GAP + 2;
      end
      lost_now = $countones(g & pend_m & ~clr);
      pend_m   = (pend_m & ~clr) | g;
      lost_m   = (lost_m + lost_now > 255) ? 255 : lost_m + lost_now;
   endtask

   task automatic observe();
      if (valid) begin
         chk("go_o", 32'(go_o), 32'(n == fire_c));
         chk("busy_o", 32'(busy_o), 32'(n >= fire_c && n <= fire_c + GAP));
         chk("id_o", 32'(id_o), 32'(id_m));
         chk("pend_o", 32'(pend_o), 32'(pend_m));
`ifdef GO_ARB_LOST_CNT_EN
         chk("lost_cnt_o", 32'(lost_cnt_o), 32'(lost_m));
`endif
         if (go_o === 1'b1) begin
            ev_t.push_back(n);
            ev_id.push_back(int'(id_o));
         end
      end
   endtask

   // One clock cycle: drive inputs, check outputs, clock, advance the model.
   task automatic cycle(input logic [NREQ-1:0] g, input logic e, input logic r);
      go_i = g;
      en_i = e;
      rst  = r;
      observe();
      @(posedge clk);
      if (r) model_reset();
      else   model_adv(g, e);
      #1;
      n++;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) cycle('0, 1'b1, 1'b0);
   endtask

   task automatic reset_dut();
      cycle('0, 1'b1, 1'b1);
      ev_t.delete();
      ev_id.delete();
   endtask

   initial begin
      // Power-on reset; outputs are unknown until the first reset edge.
      rst  = 1'b1;
      go_i = '0;
      en_i = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      n++;
      valid = 1'b1;

      // Reset state
      chk("rst go_o", 32'(go_o), 32'd0);
      chk("rst id_o", 32'(id_o), 32'd0);
      chk("rst pend_o", 32'(pend_o), 32'd0);
      chk("rst busy_o", 32'(busy_o), 32'd0);

      // Single request on requester 2: pulse two cycles later, once
      reset_dut();
      idle(3);
      t = n;
      cycle(4'b0100, 1'b1, 1'b0);
      idle(20);
      chk("single count", 32'(ev_t.size()), 32'd1);
      if (ev_t.size() > 0) begin
         chk("single latency", 32'(ev_t[0] - t), 32'd2);
         chk("single id", 32'(ev_id[0]), 32'd2);
      end

      // Fairness: all four at once, served 0..3 every GAP+2 cycles
      reset_dut();
      t = n;
      cycle(4'b1111, 1'b1, 1'b0);
      idle(30);
      chk("fair count", 32'(ev_t.size()), 32'd4);
      for (int i = 0; i < ev_t.size() && i < 4; i++) begin
         chk("fair time", 32'(ev_t[i] - t), 32'(2 + (GAP + 2) * i));
         chk("fair id", 32'(ev_id[i]), 32'(i));
      end
      chk("fair pend end", 32'(pend_o), 32'd0);

      // Set wins over the grant-edge clear
      reset_dut();
      t = n;
      cycle(4'b0010, 1'b1, 1'b0);
      cycle(4'b0010, 1'b1, 1'b0);
      idle(20);
      chk("setwin count", 32'(ev_t.size()), 32'd2);
      if (ev_t.size() == 2) begin
         chk("setwin spacing", 32'(ev_t[1] - ev_t[0]), 32'(GAP + 2));
         chk("setwin id0", 32'(ev_id[0]), 32'd1);
         chk("setwin id1", 32'(ev_id[1]), 32'd1);
      end

      // en_i gating: requests accumulate, then drain in order once enabled
      reset_dut();
      cycle(4'b0011, 1'b0, 1'b0);
      repeat (5) cycle('0, 1'b0, 1'b0);
      chk("gate pend", 32'(pend_o), 32'b0011);
      chk("gate no go", 32'(ev_t.size()), 32'd0);
      u = n;
      idle(20);
      chk("gate count", 32'(ev_t.size()), 32'd2);
      if (ev_t.size() == 2) begin
         chk("gate t0", 32'(ev_t[0] - u), 32'd1);
         chk("gate t1", 32'(ev_t[1] - u), 32'(GAP + 3));
         chk("gate id0", 32'(ev_id[0]), 32'd0);
         chk("gate id1", 32'(ev_id[1]), 32'd1);
      end

      // Reset during GAP, three cycles after go_o
      reset_dut();
      t = n;
      cycle(4'b0001, 1'b1, 1'b0);
      idle(4);
      chk("midgap busy", 32'(busy_o), 32'd1);
      reset_dut();
      chk("midgap pend", 32'(pend_o), 32'd0);
      chk("midgap busy after", 32'(busy_o), 32'd0);
      idle(10);
      chk("midgap no go", 32'(ev_t.size()), 32'd0);

`ifdef GO_ARB_LOST_CNT_EN
      // Lost-request saturation
      reset_dut();
      repeat (300) cycle(4'b1000, 1'b0, 1'b0);
      chk("lost sat", 32'(lost_cnt_o), 32'd255);
      chk("lost pend", 32'(pend_o), 32'b1000);
`endif

      // Randomized traffic with occasional enable drops and resets
      reset_dut();
      for (int i = 0; i < 800; i++) begin
         logic [NREQ-1:0] g;
         logic            e;
         logic            r;
         g = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
         e = ($urandom_range(0, 7) != 0);
         r = ($urandom_range(0, 99) == 0);
         cycle(g, e, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
